// File: rtl/line_stream_gen.sv
// Converts raw video timing (vs/hs/de + pixel) into the line-buffer write protocol for the 3-line window.
// Optional bad-line counter on err_cnt_o is built when LINE_STREAM_ERRCNT_EN is defined.
module line_stream_gen #(
    parameter int COLORDEPTH  = 8,
    parameter int SCREENWIDTH = 1600,
    parameter int MAX_LINES   = 1200
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               vs_i,
    input  logic                               hs_i,
    input  logic                               de_i,
    input  logic [COLORDEPTH-1:0]              data_i,
    output logic [COLORDEPTH-1:0]              data_o,
    output logic                               dv_o,
    output logic                               line_end_o,
    output logic                               frame_start_o,
    output logic [$clog2(MAX_LINES+1)-1:0]     line_cnt_o,
    output logic                               win_valid_o,
    output logic                               ovf_o,
    output logic                               short_o,
    output logic [15:0]                        err_cnt_o
);

    localparam int LW = $clog2(MAX_LINES + 1);
    localparam int CW = $clog2(SCREENWIDTH + 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(SCREENWIDTH);
    localparam logic [LW-1:0] LINE_MAX = LW'(MAX_LINES);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        WAIT_DE,
        ACTIVE
    } state_t;

    state_t        state;
    logic          vs_q;
    logic [CW-1:0] col;
    logic          hs_bad;
    logic          frame_pending;
    logic          vs_rise;
    logic [LW-1:0] line_cnt_inc;

    assign vs_rise      = vs_i & ~vs_q;
    assign line_cnt_inc = (line_cnt_o == LINE_MAX) ? line_cnt_o : line_cnt_o + 1'b1;

    // NOTE: all state is updated with non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= WAIT_FRAME;
            vs_q          <= 1'b0;
            col           <= '0;
            hs_bad        <= 1'b0;
            frame_pending <= 1'b0;
            data_o        <= '0;
            dv_o          <= 1'b0;
            line_end_o    <= 1'b0;
            frame_start_o <= 1'b0;
            line_cnt_o    <= '0;
            win_valid_o   <= 1'b0;
            ovf_o         <= 1'b0;
            short_o       <= 1'b0;
        end else begin
            vs_q          <= vs_i;
            data_o        <= data_i;
            dv_o          <= 1'b0;
            line_end_o    <= 1'b0;
            frame_start_o <= 1'b0;
            if (vs_rise) begin
                // A new frame wins over any line in flight; a truncated line still gets its line_end.
                state         <= WAIT_DE;
                line_end_o    <= (state == ACTIVE);
                col           <= '0;
                hs_bad        <= 1'b0;
                frame_pending <= 1'b1;
                line_cnt_o    <= '0;
                win_valid_o   <= 1'b0;
                ovf_o         <= 1'b0;
                short_o       <= 1'b0;
            end else begin
                case (state)
                    WAIT_FRAME: ;
                    WAIT_DE: begin
                        if (de_i) begin
                            state         <= ACTIVE;
                            dv_o          <= 1'b1;
                            col           <= CW'(1);
                            hs_bad        <= hs_i;
                            frame_start_o <= frame_pending;
                            frame_pending <= 1'b0;
                        end
                    end
                    ACTIVE: begin
                        if (de_i) begin
                            if (hs_i) hs_bad <= 1'b1;
                            if (col < COL_MAX) begin
                                dv_o <= 1'b1;
                                col  <= col + 1'b1;
                            end else begin
                                ovf_o <= 1'b1;
                            end
                        end else begin
                            state       <= WAIT_DE;
                            line_end_o  <= 1'b1;
                            col         <= '0;
                            line_cnt_o  <= line_cnt_inc;
                            win_valid_o <= (line_cnt_inc >= LW'(2));
                            if ((col < COL_MAX) || hs_bad) short_o <= 1'b1;
                        end
                    end
                    default: state <= WAIT_FRAME;
                endcase
            end
        end
    end

`ifdef LINE_STREAM_ERRCNT_EN
    logic line_ovf;
    logic line_bad_end;

    // Per-line overflow flag; the frame-level ovf_o cannot tell which line overflowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_ovf <= 1'b0;
        end else if (vs_rise || (state == WAIT_DE && de_i)) begin
            line_ovf <= 1'b0;
        end else if (state == ACTIVE && de_i && col == COL_MAX) begin
            line_ovf <= 1'b1;
        end
    end

    assign line_bad_end = !vs_rise && (state == ACTIVE) && !de_i &&
                          (line_ovf || (col < COL_MAX) || hs_bad);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_o <= '0;
        end else if (line_bad_end && err_cnt_o != 16'hFFFF) begin
            err_cnt_o <= err_cnt_o + 16'd1;
        end
    end
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_line_stream_gen.sv
// Directed self-checking bench for line_stream_gen at default parameters (1600 x 1200, 8-bit pixels).
module tb_line_stream_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs_i, hs_i, de_i;
    logic [7:0]  data_i;
    logic [7:0]  data_o;
    logic        dv_o, line_end_o, frame_start_o, win_valid_o, ovf_o, short_o;
    logic [10:0] line_cnt_o;
    logic [15:0] err_cnt_o;

    int total = 0;
    int bad   = 0;
    int dv_cnt, le_cnt, fs_cnt, fs_lone, overlap, data_err;

    line_stream_gen dut (
        .clk           (clk),
        .rst           (rst),
        .vs_i          (vs_i),
        .hs_i          (hs_i),
        .de_i          (de_i),
        .data_i        (data_i),
        .data_o        (data_o),
        .dv_o          (dv_o),
        .line_end_o    (line_end_o),
        .frame_start_o (frame_start_o),
        .line_cnt_o    (line_cnt_o),
        .win_valid_o   (win_valid_o),
        .ovf_o         (ovf_o),
        .short_o       (short_o),
        .err_cnt_o     (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        dv_cnt = 0; le_cnt = 0; fs_cnt = 0; fs_lone = 0; overlap = 0; data_err = 0;
    endtask

    // One clock: inputs were set before the edge, outputs are observed 1 time unit after it.
    task automatic step();
        logic [7:0] d_prev;
        d_prev = data_i;
        @(posedge clk);
        #1;
        if (dv_o) dv_cnt++;
        if (line_end_o) le_cnt++;
        if (frame_start_o) begin
            fs_cnt++;
            if (!dv_o) fs_lone++;
        end
        if (dv_o && line_end_o) overlap++;
        if (dv_o && data_o !== d_prev) data_err++;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic de_run(input int n, input int hs_at);
        for (int i = 0; i < n; i++) begin
            de_i   = 1'b1;
            data_i = 8'(i);
            hs_i   = (i == hs_at);
            step();
        end
        hs_i = 1'b0;
    endtask

    // Full line: n de cycles, de fall, short blanking.
    task automatic line(input int n, input int hs_at);
        de_run(n, hs_at);
        de_i = 1'b0;
        step();
        gap(3);
    endtask

    task automatic vs_pulse();
        vs_i = 1'b1;
        step();
        vs_i = 1'b0;
        gap(3);
    endtask

    initial begin
        rst = 1'b1; vs_i = 1'b0; hs_i = 1'b0; de_i = 1'b0; data_i = 8'h00;
        #12;
        check("reset_dv", dv_o, 0);
        check("reset_line_cnt", line_cnt_o, 0);
        check("reset_flags", {line_end_o, frame_start_o, win_valid_o, ovf_o, short_o}, 0);
        check("reset_err_cnt", err_cnt_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        gap(2);

        // Activity before the first vs rise is never written.
        clear_counts();
        line(20, -1);
        line(20, -1);
        check("prevs_dv_cnt", dv_cnt, 0);
        check("prevs_line_end", le_cnt, 0);
        check("prevs_line_cnt", line_cnt_o, 0);

        // Three nominal lines.
        vs_pulse();
        clear_counts();
        line(1600, -1);
        check("l1_dv_cnt", dv_cnt, 1600);
        check("l1_line_cnt", line_cnt_o, 1);
        check("l1_win_valid", win_valid_o, 0);
        line(1600, -1);
        check("l2_line_cnt", line_cnt_o, 2);
        check("l2_win_valid", win_valid_o, 1);
        line(1600, -1);
        check("l3_line_cnt", line_cnt_o, 3);
        check("l3_win_valid", win_valid_o, 1);
        check("nom_dv_cnt", dv_cnt, 4800);
        check("nom_line_end_cnt", le_cnt, 3);
        check("nom_frame_start_cnt", fs_cnt, 1);
        check("nom_data_err", data_err, 0);
        check("nom_ovf_short", {ovf_o, short_o}, 0);

        // Over-long line is truncated at 1600 writes.
        clear_counts();
        de_run(1610, -1);
        check("ovf_flag_during", ovf_o, 1);
        de_i = 1'b0;
        step();
        check("ovf_line_end_after_fall", line_end_o, 1);
        gap(3);
        check("ovf_dv_cnt", dv_cnt, 1600);
        check("ovf_line_end_cnt", le_cnt, 1);
        check("ovf_short", short_o, 0);
        check("ovf_line_cnt", line_cnt_o, 4);
`ifdef LINE_STREAM_ERRCNT_EN
        check("ovf_err_cnt", err_cnt_o, 1);
`else
        check("ovf_err_cnt", err_cnt_o, 0);
`endif

        // Short line in a fresh frame.
        vs_pulse();
        check("vs_clears_ovf", ovf_o, 0);
        check("vs_clears_line_cnt", line_cnt_o, 0);
        check("vs_clears_win_valid", win_valid_o, 0);
        clear_counts();
        line(1000, -1);
        check("short_dv_cnt", dv_cnt, 1000);
        check("short_flag", short_o, 1);
        check("short_line_cnt", line_cnt_o, 1);
        check("short_frame_start", fs_cnt, 1);
        vs_pulse();
        check("vs_clears_short", short_o, 0);
        check("vs_short_line_cnt", line_cnt_o, 0);

        // Truncated line: vs rise at col=500 after one full line.
        line(1600, -1);
        check("trunc_pre_line_cnt", line_cnt_o, 1);
        clear_counts();
        de_run(500, -1);
        de_i = 1'b0;
        vs_i = 1'b1;
        step();
        check("trunc_line_end", line_end_o, 1);
        check("trunc_line_cnt", line_cnt_o, 0);
        check("trunc_short", short_o, 0);
        vs_i = 1'b0;
        gap(3);
        de_i = 1'b1; data_i = 8'h5A;
        step();
        check("trunc_next_first_dv", {dv_o, frame_start_o}, 2'b11);
        de_run(1599, -1);
        de_i = 1'b0;
        gap(4);
        check("trunc_dv_cnt", dv_cnt, 2100);
        check("trunc_line_end_cnt", le_cnt, 2);
        check("trunc_frame_start_cnt", fs_cnt, 1);
        check("trunc_next_line_cnt", line_cnt_o, 1);

        // hs during de marks the line bad but the data still passes.
        clear_counts();
        line(1600, 700);
        check("hs_dv_cnt", dv_cnt, 1600);
        check("hs_short", short_o, 1);
        check("hs_ovf", ovf_o, 0);

        // Single-cycle line.
        vs_pulse();
        clear_counts();
        de_run(1, -1);
        de_i = 1'b0;
        step();
        check("single_line_end", {dv_o, line_end_o}, 2'b01);
        gap(3);
        check("single_dv_cnt", dv_cnt, 1);
        check("single_short", short_o, 1);
        check("single_frame_start", fs_cnt, 1);
`ifdef LINE_STREAM_ERRCNT_EN
        check("single_err_cnt", err_cnt_o, 4);
`else
        check("single_err_cnt", err_cnt_o, 0);
`endif

        check("run_data_err", data_err, 0);
        check("run_dv_line_end_overlap", overlap, 0);
        check("run_frame_start_without_dv", fs_lone, 0);

        // Asynchronous reset in the middle of a line.
        vs_pulse();
        de_run(800, -1);
        check("midrst_dv_before", dv_o, 1);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_dv_immediate", dv_o, 0);
        check("midrst_data_immediate", data_o, 0);
        check("midrst_line_cnt", line_cnt_o, 0);
        check("midrst_err_cnt", err_cnt_o, 0);
        clear_counts();
        de_i = 1'b0;
        gap(2);
        rst = 1'b0;
        gap(2);
        line(30, -1);
        check("midrst_no_line_end", le_cnt, 0);
        check("midrst_wait_frame_dv", dv_cnt, 0);
        check("midrst_wait_frame_cnt", line_cnt_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
